mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It serializes accesses and gives data accesses priority, with a starvation guard for fetches. It cancels in-flight fetches on branch/jump flush and drives a pipeline stall output so the hazard unit can freeze the front end while an access is pending.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and
// load/store, with data priority, a fetch starvation guard, flush cancel and ack timeout.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_valid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_BUSY,
    S_DM_BUSY,
    S_IF_DROP,
    S_DONE
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_streak;
  logic [7:0]  r_tmo;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_if_done;
  logic        r_dm_done;
  logic        r_err;

  logic        w_eff_if;
  logic        w_busy;
  logic        w_ack;
  logic        w_tmo;
  logic        w_end;
  logic        w_grant_dm;
  logic        w_grant_if;
  logic [31:0] w_cap;

  assign w_eff_if = if_req_i & ~flush_i;
  assign w_busy   = (r_state == S_IF_BUSY) | (r_state == S_DM_BUSY) | (r_state == S_IF_DROP);
  assign w_ack    = w_busy & mem_ack_i;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign w_tmo    = w_busy & ~mem_ack_i & (r_tmo == TMO_LAST);
  assign w_end    = w_ack | w_tmo;
  assign w_cap    = w_ack ? mem_rdata_i : '0;

  always_comb begin
    w_grant_dm = 1'b0;
    w_grant_if = 1'b0;
    if (r_state == S_IDLE) begin
      if (dm_req_i && !(w_eff_if && (r_streak == STREAK_MAX))) begin
        w_grant_dm = 1'b1;
      end else if (w_eff_if) begin
        w_grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dm) begin
          w_next = S_DM_BUSY;
        end else if (w_grant_if) begin
          w_next = S_IF_BUSY;
        end
      end
      S_IF_BUSY: begin
        if (w_end) begin
          w_next = S_DONE;
        end else if (flush_i) begin
          w_next = S_IF_DROP;
        end
      end
      S_DM_BUSY, S_IF_DROP: begin
        if (w_end) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_streak    <= '0;
      r_tmo       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Done flags live only for the single DONE cycle that follows completion.
      r_if_done <= w_end & (r_state == S_IF_BUSY) & ~flush_i;
      r_dm_done <= w_end & (r_state == S_DM_BUSY);

      if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_we_i;
        r_mem_be    <= dm_be_i;
        r_mem_addr  <= dm_addr_i;
        r_mem_wdata <= dm_wdata_i;
        r_tmo       <= '0;
        if (!w_eff_if) begin
          r_streak <= '0;
        end else if (r_streak != STREAK_MAX) begin
          r_streak <= r_streak + 4'd1;
        end
      end else if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= 4'hF;
        r_mem_addr  <= if_addr_i;
        r_mem_wdata <= '0;
        r_tmo       <= '0;
        r_streak    <= '0;
      end else if (w_end) begin
        r_mem_req <= 1'b0;
      end else if (w_busy) begin
        r_tmo <= r_tmo + 8'd1;
      end

      if (w_end && (r_state == S_IF_BUSY)) begin
        r_if_rdata <= w_cap;
      end
      if (w_end && (r_state == S_DM_BUSY)) begin
        r_dm_rdata <= w_cap;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    if_valid_o = 1'b0;
    dm_valid_o = 1'b0;
    if (r_state == S_DONE) begin
      if_valid_o = r_if_done & ~flush_i;
      dm_valid_o = r_dm_done;
    end
    stall_o = (dm_req_i & ~dm_valid_o) | (if_req_i & ~flush_i & ~if_valid_o);
  end

  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: requests are queued, expected
// grants and read data are queued alongside, and both are checked as the DUT responds.
module tb_mem_port_arbiter;

  localparam logic [31:0] RD_KEY = 32'hCAFE_F10D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, flush_i, if_valid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_valid_o;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_o, err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  // Memory model: acks after mem_wait extra cycles, read data derived from the address.
  int unsigned wcnt = 0;
  int unsigned mem_wait = 0;
  bit          ack_en = 1'b1;
  bit          force_ack = 1'b0;
  assign mem_ack_i   = (mem_req_o & ack_en & (wcnt == mem_wait)) | force_ack;
  assign mem_rdata_i = mem_addr_o ^ RD_KEY;
  always @(posedge clk) wcnt <= (mem_req_o && !mem_ack_i) ? wcnt + 1 : 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wd;
  } acc_t;

  acc_t        dm_stim[$];
  logic [31:0] if_stim[$];
  acc_t        exp_grant[$];
  logic [31:0] exp_dm[$];
  logic [31:0] exp_if[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int rise_cyc = 0;
  int n_if_valid = 0;
  bit flush_drv = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_dm(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    acc_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd; r.chk_wd = 1'b1;
    dm_stim.push_back(r);
  endtask

  task automatic grant_dm(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
    acc_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd; r.chk_wd = 1'b1;
    exp_grant.push_back(r);
  endtask

  task automatic grant_if(input logic [31:0] a);
    acc_t r;
    r.addr = a; r.we = 1'b0; r.be = 4'hF; r.wdata = '0; r.chk_wd = 1'b0;
    exp_grant.push_back(r);
  endtask

  // One clock: drive queue heads, then sample and score grants and valid pulses.
  task automatic cyc();
    acc_t        g;
    logic [31:0] v;
    @(posedge clk); #1;
    cyc_n++;
    if (dm_stim.size() > 0) begin
      dm_req_i = 1'b1; dm_we_i = dm_stim[0].we; dm_be_i = dm_stim[0].be;
      dm_addr_i = dm_stim[0].addr; dm_wdata_i = dm_stim[0].wdata;
    end else begin
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    end
    if (if_stim.size() > 0) begin
      if_req_i = 1'b1; if_addr_i = if_stim[0];
    end else begin
      if_req_i = 1'b0; if_addr_i = '0;
    end
    flush_i = flush_drv;
    #1;
    if (mem_req_o && !prev_req) begin
      rise_cyc = cyc_n;
      chk("grant_expected", 32'(exp_grant.size() > 0), 1);
      if (exp_grant.size() > 0) begin
        g = exp_grant.pop_front();
        chk("grant_addr", mem_addr_o, g.addr);
        chk("grant_we", 32'(mem_we_o), 32'(g.we));
        chk("grant_be", 32'(mem_be_o), 32'(g.be));
        if (g.chk_wd) chk("grant_wdata", mem_wdata_o, g.wdata);
      end
    end
    prev_req = mem_req_o;
    if (dm_valid_o) begin
      chk("dm_valid_expected", 32'(exp_dm.size() > 0), 1);
      if (exp_dm.size() > 0) begin
        v = exp_dm.pop_front();
        chk("dm_rdata", dm_rdata_o, v);
      end
      if (dm_stim.size() > 0) void'(dm_stim.pop_front());
    end
    if (if_valid_o) begin
      n_if_valid++;
      chk("if_valid_expected", 32'(exp_if.size() > 0), 1);
      if (exp_if.size() > 0) begin
        v = exp_if.pop_front();
        chk("if_rdata", if_rdata_o, v);
      end
      if (if_stim.size() > 0) void'(if_stim.pop_front());
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((dm_stim.size() > 0 || if_stim.size() > 0 || exp_grant.size() > 0 || mem_req_o)
           && n < max) begin
      cyc();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < max), 1);
    chk({tag, "_leftover"}, exp_dm.size() + exp_if.size() + exp_grant.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int hi;
    int flush_at;
    int nv0;

    rst_n = 1'b0;
    if_req_i = 0; if_addr_i = '0; flush_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_valids", {if_valid_o, dm_valid_o}, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rdata", dm_rdata_o | if_rdata_o, 0);
    rst_n = 1'b1;
    cyc();

    // Single load acked in the first request cycle
    push_dm(32'h100, 1'b0, 4'hF, '0);
    grant_dm(32'h100, 1'b0, 4'hF, '0);
    exp_dm.push_back(32'hCAFE_F00D);
    cyc();
    chk("ld_c0_stall", stall_o, 1);
    chk("ld_c0_req", mem_req_o, 0);
    cyc();
    chk("ld_c1_stall", stall_o, 1);
    chk("ld_c1_req", mem_req_o, 1);
    cyc();
    chk("ld_c2_valid", dm_valid_o, 1);
    chk("ld_c2_stall", stall_o, 0);
    chk("ld_c2_req", mem_req_o, 0);
    cyc();
    chk("ld_c3_valid", dm_valid_o, 0);

    // Both ports requesting continuously: four data grants, then a fetch
    mem_wait = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) push_dm(32'h200 + 32'(4 * i), 1'b1, 4'b0011, 32'hDEAD_0000 + 32'(i));
      else        push_dm(32'h200 + 32'(4 * i), 1'b0, 4'hF, '0);
      exp_dm.push_back((32'h200 + 32'(4 * i)) ^ RD_KEY);
    end
    if_stim.push_back(32'h1000);
    if_stim.push_back(32'h1004);
    exp_if.push_back(32'h1000 ^ RD_KEY);
    exp_if.push_back(32'h1004 ^ RD_KEY);
    grant_dm(32'h200, 1'b0, 4'hF, '0);
    grant_dm(32'h204, 1'b1, 4'b0011, 32'hDEAD_0001);
    grant_dm(32'h208, 1'b0, 4'hF, '0);
    grant_dm(32'h20C, 1'b0, 4'hF, '0);
    grant_if(32'h1000);
    grant_dm(32'h210, 1'b0, 4'hF, '0);
    grant_dm(32'h214, 1'b0, 4'hF, '0);
    grant_if(32'h1004);
    drain("streak", 200);

    // Flush while a fetch is in flight; memory acks after three wait cycles
    mem_wait = 3;
    nv0 = n_if_valid;
    if_stim.push_back(32'h2000);
    grant_if(32'h2000);
    cyc();
    cyc();
    chk("drop_busy_req", mem_req_o, 1);
    void'(if_stim.pop_front());
    flush_drv = 1'b1;
    cyc();
    flush_at = cyc_n;
    flush_drv = 1'b0;
    if_stim.push_back(32'h3000);
    grant_if(32'h3000);
    exp_if.push_back(32'h3000 ^ RD_KEY);
    drain("drop", 100);
    chk("drop_regrant_delay", rise_cyc - flush_at, 5);
    chk("drop_valid_count", n_if_valid - nv0, 1);

    // Flush in IDLE with both requesting: data wins, the fetch is dropped
    mem_wait = 0;
    flush_drv = 1'b1;
    if_stim.push_back(32'h5000);
    push_dm(32'h400, 1'b0, 4'hF, '0);
    grant_dm(32'h400, 1'b0, 4'hF, '0);
    exp_dm.push_back(32'h400 ^ RD_KEY);
    cyc();
    chk("idle_flush_stall", stall_o, 1);
    flush_drv = 1'b0;
    void'(if_stim.pop_front());
    drain("idle_flush", 50);

    // Flush in IDLE with only a fetch: nothing is granted
    flush_drv = 1'b1;
    if_stim.push_back(32'h5100);
    cyc();
    chk("if_only_flush_stall", stall_o, 0);
    flush_drv = 1'b0;
    void'(if_stim.pop_front());
    cyc();
    chk("if_only_flush_req", mem_req_o, 0);

    // Flush in the DONE cycle suppresses the fetch valid
    if_stim.push_back(32'h6000);
    grant_if(32'h6000);
    cyc();
    cyc();
    flush_drv = 1'b1;
    cyc();
    chk("done_flush_valid", if_valid_o, 0);
    chk("done_flush_stall", stall_o, 0);
    flush_drv = 1'b0;
    void'(if_stim.pop_front());
    cyc();
    chk("done_flush_after", if_valid_o, 0);

    // Timeout: no ack ever arrives
    ack_en = 1'b0;
    push_dm(32'h700, 1'b0, 4'hF, '0);
    grant_dm(32'h700, 1'b0, 4'hF, '0);
    exp_dm.push_back(32'h0);
    cyc();
    chk("tmo_err_before", err_o, 0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req_o) hi++;
      else break;
    end
    chk("tmo_req_cycles", hi, 8);
    chk("tmo_valid", dm_valid_o, 1);
    chk("tmo_err", err_o, 1);
    ack_en = 1'b1;
    push_dm(32'h704, 1'b0, 4'hF, '0);
    grant_dm(32'h704, 1'b0, 4'hF, '0);
    exp_dm.push_back(32'h704 ^ RD_KEY);
    drain("post_tmo", 50);
    chk("tmo_err_sticky", err_o, 1);

    // Reset during a data access, then a late ack
    mem_wait = 5;
    push_dm(32'h800, 1'b0, 4'hF, '0);
    grant_dm(32'h800, 1'b0, 4'hF, '0);
    cyc();
    cyc();
    chk("rst_mid_req_before", mem_req_o, 1);
    rst_n = 1'b0;
    dm_stim.delete();
    cyc();
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_addr", mem_addr_o, 0);
    chk("rst_mid_err", err_o, 0);
    chk("rst_mid_valid", dm_valid_o, 0);
    chk("rst_mid_rdata", dm_rdata_o, 0);
    rst_n = 1'b1;
    force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("late_ack_valid", {if_valid_o, dm_valid_o}, 0);
      chk("late_ack_req", mem_req_o, 0);
    end
    force_ack = 1'b0;
    mem_wait = 0;
    push_dm(32'h900, 1'b0, 4'hF, '0);
    grant_dm(32'h900, 1'b0, 4'hF, '0);
    exp_dm.push_back(32'h900 ^ RD_KEY);
    t0 = cyc_n + 1;
    drain("post_rst", 50);
    chk("post_rst_latency", rise_cyc - t0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
